// File: rtl/calc_pkg.sv
// Shared types and key encoding for the keypad front end.
// Imported by the scanner and by the digit-accumulation stage.
package calc_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] keymap(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    unique case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_A;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_B;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Reset value is a parameter so idle-high lines come up idle.
module sync_2ff #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with tick-sampled debounce.
// One key_valid strobe per accepted press; key_held until release.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CntW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [3:0]      rs;
  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      pat_q, pat_d;
  logic [CntW-1:0] dcnt_q, dcnt_d;
  logic [CntW-1:0] dcnt_nx;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic            one_low;
  logic [1:0]      row_idx;
  logic            all_high;
  logic            accept;
  logic            done;

  sync_2ff #(
    .WIDTH  (4),
    .RST_VAL(4'hF)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rows),
    .q_o  (rs)
  );

  assign tick     = (div_q == DivLast);
  assign div_d    = tick ? '0 : div_q + DivW'(1);
  assign all_high = &rs;
  assign dcnt_nx  = dcnt_q + CntOne;

  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (rs)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pat_d   = pat_q;
    dcnt_d  = dcnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    accept  = 1'b0;
    done    = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (one_low) begin
            row_d  = row_idx;
            pat_d  = rs;
            dcnt_d = CntOne;
            if (DEBOUNCE_CNT == 1) accept = 1'b1;
            else state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rs == pat_q) begin
            dcnt_d = dcnt_nx;
            if (dcnt_nx == CntLast) accept = 1'b1;
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
            dcnt_d  = '0;
          end
        end
        PRESSED: begin
          // Other keys are ignored; only an all-released sample counts.
          if (all_high) begin
            dcnt_d = CntOne;
            if (DEBOUNCE_CNT == 1) done = 1'b1;
            else state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (all_high) begin
            dcnt_d = dcnt_nx;
            if (dcnt_nx == CntLast) done = 1'b1;
          end else begin
            state_d = PRESSED;
            dcnt_d  = '0;
          end
        end
      endcase
    end
    if (accept) begin
      state_d = PRESSED;
      code_d  = keymap(row_d, col_q);
      valid_d = 1'b1;
      held_d  = 1'b1;
      dcnt_d  = '0;
    end
    if (done) begin
      state_d = SCAN;
      col_d   = col_q + 2'd1;
      held_d  = 1'b0;
      dcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      pat_q   <= 4'hF;
      dcnt_q  <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      dcnt_q  <= dcnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a physical keypad model.
// SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam int PRESS_BUDGET = (4 + DC) * SD + 4;
  localparam int REL_BUDGET   = (DC + 1) * SD + 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic key_dn [4][4];

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;
  logic [3:0] strobe_q [$];
  logic [3:0] exp_q [$];
  logic prev_held  = 1'b0;
  logic prev_valid = 1'b0;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;
  vec_t vt [16];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // A pressed switch shorts its row to its column when that column is low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_dn[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if ($countones(~cols) != 1) begin
      viol++;
      $display("invariant broken at %0t: cols=%b", $time, cols);
    end
    if (key_valid && (prev_held || prev_valid || !key_held)) begin
      viol++;
      $display("invariant broken at %0t: strobe with held history %b/%b/%b",
               $time, prev_held, prev_valid, key_held);
    end
    if (key_valid) strobe_q.push_back(key_code);
    prev_held  = key_held;
    prev_valid = key_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) key_dn[r][c] = 1'b0;
  endtask

  task automatic wait_strobe(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (strobe_q.size() > base) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    if (strobe_q.size() > base) ok = 1'b1;
  endtask

  task automatic wait_unheld(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!key_held) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    if (!key_held) ok = 1'b1;
  endtask

  function automatic logic [3:0] ref_code(input int r, input int c);
    string km;
    byte   ch;
    km = "123A456B789C*0#D";
    ch = km[r * 4 + c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
    if (ch == "*") return 4'hE;
    return 4'hF;
  endfunction

  initial begin
    bit ok;
    int base;
    int rbase;
    int nchg;
    logic [3:0] cprev;
    logic [3:0] c_before;

    vt[0]  = '{0, 0, 4'h1}; vt[1]  = '{0, 1, 4'h2};
    vt[2]  = '{0, 2, 4'h3}; vt[3]  = '{0, 3, 4'hA};
    vt[4]  = '{1, 0, 4'h4}; vt[5]  = '{1, 1, 4'h5};
    vt[6]  = '{1, 2, 4'h6}; vt[7]  = '{1, 3, 4'hB};
    vt[8]  = '{2, 0, 4'h7}; vt[9]  = '{2, 1, 4'h8};
    vt[10] = '{2, 2, 4'h9}; vt[11] = '{2, 3, 4'hC};
    vt[12] = '{3, 0, 4'hE}; vt[13] = '{3, 1, 4'h0};
    vt[14] = '{3, 2, 4'hF}; vt[15] = '{3, 3, 4'hD};

    release_all();
    rst_n = 1'b0;
    cyc(3);
    chk("rst_cols", cols, 4'hE);
    chk("rst_code", key_code, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    rst_n = 1'b1;
    cyc(10);

    // 1: long press of '5'
    base = strobe_q.size();
    key_dn[1][1] = 1'b1;
    wait_strobe(base, PRESS_BUDGET, ok);
    chk("t1_latency", ok, 1);
    cyc(200 - PRESS_BUDGET);
    chk("t1_count", strobe_q.size() - base, 1);
    chk("t1_code", key_code, 4'h5);
    chk("t1_held", key_held, 1);
    key_dn[1][1] = 1'b0;
    cyc(8);
    chk("t1_held_early", key_held, 1);
    wait_unheld(REL_BUDGET, ok);
    chk("t1_unheld", ok, 1);
    c_before = cols;
    cyc(SD);
    chk("t1_rotate", cols != c_before, 1);
    cyc(10);

    // 2: short '*' tap, never accepted
    base = strobe_q.size();
    for (int i = 0; i < 40 && cols != 4'hE; i++) cyc(1);
    key_dn[3][0] = 1'b1;
    cyc(2 * SD);
    key_dn[3][0] = 1'b0;
    cyc(60);
    chk("t2_count", strobe_q.size() - base, 0);
    chk("t2_code", key_code, 4'h5);
    chk("t2_held", key_held, 0);

    // 3: '0' with one-tick release glitches
    base = strobe_q.size();
    key_dn[3][1] = 1'b1;
    wait_strobe(base, PRESS_BUDGET, ok);
    chk("t3_latency", ok, 1);
    for (int g = 0; g < 3; g++) begin
      cyc(20);
      key_dn[3][1] = 1'b0;
      cyc(SD);
      key_dn[3][1] = 1'b1;
    end
    cyc(20);
    chk("t3_held", key_held, 1);
    key_dn[3][1] = 1'b0;
    wait_unheld(REL_BUDGET, ok);
    chk("t3_unheld", ok, 1);
    cyc(30);
    chk("t3_count", strobe_q.size() - base, 1);
    chk("t3_code", key_code, 4'h0);

    // 4: two rows low in column 2
    base = strobe_q.size();
    key_dn[0][2] = 1'b1;
    key_dn[2][2] = 1'b1;
    nchg = 0;
    cprev = cols;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (cols != cprev) nchg++;
      cprev = cols;
    end
    release_all();
    chk("t4_count", strobe_q.size() - base, 0);
    chk("t4_rotating", nchg >= 45, 1);
    cyc(20);

    // 5: reset while '9' is held
    base = strobe_q.size();
    key_dn[2][2] = 1'b1;
    wait_strobe(base, PRESS_BUDGET, ok);
    chk("t5_first", ok, 1);
    cyc(15);
    rst_n = 1'b0;
    cyc(1);
    chk("t5_rst_cols", cols, 4'hE);
    chk("t5_rst_code", key_code, 0);
    chk("t5_rst_held", key_held, 0);
    cyc(2);
    chk("t5_rst_valid", key_valid, 0);
    rst_n = 1'b1;
    base = strobe_q.size();
    wait_strobe(base, PRESS_BUDGET, ok);
    chk("t5_restrobe", ok, 1);
    chk("t5_code", key_code, 4'h9);
    cyc(60);
    chk("t5_count", strobe_q.size() - base, 1);
    release_all();
    wait_unheld(REL_BUDGET, ok);
    chk("t5_unheld", ok, 1);
    cyc(10);

    // 6: '#' then 'D'
    base = strobe_q.size();
    key_dn[3][2] = 1'b1;
    wait_strobe(base, PRESS_BUDGET, ok);
    cyc(10);
    key_dn[3][2] = 1'b0;
    wait_unheld(REL_BUDGET, ok);
    cyc(10);
    key_dn[3][3] = 1'b1;
    wait_strobe(base + 1, PRESS_BUDGET, ok);
    cyc(10);
    key_dn[3][3] = 1'b0;
    wait_unheld(REL_BUDGET, ok);
    cyc(10);
    chk("t6_count", strobe_q.size() - base, 2);
    if (strobe_q.size() >= base + 2) begin
      chk("t6_first", strobe_q[base], 4'hF);
      chk("t6_second", strobe_q[base + 1], 4'hD);
    end

    // Table: every key in turn
    foreach (vt[i]) begin
      base = strobe_q.size();
      key_dn[vt[i].r][vt[i].c] = 1'b1;
      wait_strobe(base, PRESS_BUDGET, ok);
      chk($sformatf("tab%0d_seen", i), ok, 1);
      cyc(1);
      chk($sformatf("tab%0d_code", i), key_code, vt[i].code);
      chk($sformatf("tab%0d_held", i), key_held, 1);
      release_all();
      wait_unheld(REL_BUDGET, ok);
      chk($sformatf("tab%0d_unheld", i), ok, 1);
      cyc(10);
    end

    // Random press/tap mix against the reference keymap
    rbase = strobe_q.size();
    for (int n = 0; n < 24; n++) begin
      int r;
      int c;
      bit tap;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      tap = ($urandom_range(0, 3) == 0);
      key_dn[r][c] = 1'b1;
      if (tap) begin
        cyc($urandom_range(1, 2 * SD));
        release_all();
      end else begin
        cyc($urandom_range(PRESS_BUDGET + 4, 120));
        exp_q.push_back(ref_code(r, c));
        release_all();
        wait_unheld(REL_BUDGET, ok);
        chk("rnd_unheld", ok, 1);
      end
      cyc($urandom_range(2 * SD + 2, 20));
    end
    chk("rnd_count", strobe_q.size() - rbase, exp_q.size());
    for (int i = 0; i < exp_q.size() && rbase + i < strobe_q.size(); i++)
      chk($sformatf("rnd_code%0d", i), strobe_q[rbase + i], exp_q[i]);

    chk("invariants", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
